// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mips_pkg
//  Description : Shared types and constants for the PC sequencing logic.
//                - seq_state_e  : fetch sequencer FSM states
//                - redir_prio_e : redirect priority levels; numerically
//                                 larger value means higher priority
//                - default RESET_VECTOR / EXC_VECTOR values
//                - align_word() : clears the byte-offset bits of a target
//  Revision    : 1.0 - initial release
// ============================================================================
package mips_pkg;

    localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] EXC_VECTOR_DEFAULT   = 32'h8000_0180;
    localparam logic [31:0] PC_INCREMENT         = 32'd4;

    typedef enum logic [1:0] {
        BOOT     = 2'd0,
        WAIT_ACK = 2'd1,
        HOLD     = 2'd2
    } seq_state_e;

    // Ordering matters: relational compares between levels decide which
    // redirect wins, so keep the encoding monotonic in priority.
    typedef enum logic [2:0] {
        RD_NONE   = 3'd0,
        RD_BRANCH = 3'd1,
        RD_JUMP   = 3'd2,
        RD_JR     = 3'd3,
        RD_EXC    = 3'd4
    } redir_prio_e;

    // Instruction addresses are word aligned; the low two bits of any
    // target are discarded.
    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage : mips_pkg
`default_nettype wire

// File: rtl/pc_next_sel.sv
`default_nettype none
// ============================================================================
//  Module      : pc_next_sel
//  Description : Purely combinational next-PC selection.
//                Encodes the live redirect inputs into a single priority
//                level + aligned target, then arbitrates it against the
//                pending (latched) redirect. Live wins a priority tie.
//                Falls back to pc_q + 4 (mod 2^32) with no redirect.
//  Config      : PC_SEQ_EXC_EN - adds the exc input and the EXC_VECTOR
//                redirect at top priority.
//  Ports       : pc_q                      current PC
//                exc (PC_SEQ_EXC_EN only)  exception request
//                jr / jr_target            register jump
//                jump / jump_target        direct jump
//                branch_taken / _target    taken branch
//                pend_prio / pend_target   latched redirect
//                live_prio / live_target   encoded live redirect
//                next_pc                   selected next PC
//  Revision    : 1.0 - initial release
// ============================================================================
module pc_next_sel
    import mips_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEFAULT
) (
    input  logic [31:0] pc_q,
`ifdef PC_SEQ_EXC_EN
    input  logic        exc,
`endif
    input  logic        jr,
    input  logic [31:0] jr_target,
    input  logic        jump,
    input  logic [31:0] jump_target,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  redir_prio_e pend_prio,
    input  logic [31:0] pend_target,
    output redir_prio_e live_prio,
    output logic [31:0] live_target,
    output logic [31:0] next_pc
);

    // Priority encode the live redirect requests.
    always_comb begin
        live_prio = RD_NONE;
`ifdef PC_SEQ_EXC_EN
        if (exc) begin
            live_prio = RD_EXC;
        end else
`endif
        if (jr) begin
            live_prio = RD_JR;
        end else if (jump) begin
            live_prio = RD_JUMP;
        end else if (branch_taken) begin
            live_prio = RD_BRANCH;
        end
    end

    // Target follows the encoded level. RD_EXC cannot be reached when the
    // exception path is compiled out.
    always_comb begin
        live_target = '0;
        case (live_prio)
            RD_EXC:    live_target = align_word(EXC_VECTOR);
            RD_JR:     live_target = align_word(jr_target);
            RD_JUMP:   live_target = align_word(jump_target);
            RD_BRANCH: live_target = align_word(branch_target);
            default:   live_target = '0;
        endcase
    end

    // Pending only wins when strictly higher than the live request.
    always_comb begin
        next_pc = pc_q + PC_INCREMENT;
        if (pend_prio > live_prio) begin
            next_pc = pend_target;
        end else if (live_prio != RD_NONE) begin
            next_pc = live_target;
        end
    end

endmodule : pc_next_sel
`default_nettype wire

// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : pc_sequencer
//  Description : Instruction fetch sequencer driving an external program
//                counter register. BOOT loads RESET_VECTOR, WAIT_ACK holds
//                a fetch request at pc_q until imem_ack, HOLD parks the PC
//                while downstream stalls. Redirects seen while the PC is not
//                being updated are kept in a single pending slot and applied
//                at the next update.
//  Config      : PC_SEQ_EXC_EN - adds the exc input; exc redirects to
//                EXC_VECTOR above every other redirect.
//  Ports       : clk, rst_n                 clock / async active-low reset
//                pc_q  (in)                 current PC
//                pc_d  (out)                next PC (combinational)
//                pc_en (out)                PC load enable
//                imem_req / imem_ack        fetch handshake at pc_q
//                fetch_valid (out)          one pulse per accepted fetch
//                stall (in)                 blocks PC update
//                branch_taken/target, jump/jump_target, jr/jr_target,
//                exc (PC_SEQ_EXC_EN only)   redirect requests
//  Revision    : 1.0 - initial release
// ============================================================================
module pc_sequencer
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEFAULT,
    parameter logic [31:0] EXC_VECTOR   = EXC_VECTOR_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] pc_q,
    output logic [31:0] pc_d,
    output logic        pc_en,
    output logic        imem_req,
    input  logic        imem_ack,
    output logic        fetch_valid,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [31:0] jump_target,
    input  logic        jr,
    input  logic [31:0] jr_target
`ifdef PC_SEQ_EXC_EN
    ,
    input  logic        exc
`endif
);

    seq_state_e  state_q;
    seq_state_e  state_d;
    redir_prio_e pend_prio_q;
    redir_prio_e pend_prio_d;
    logic [31:0] pend_target_q;
    logic [31:0] pend_target_d;

    redir_prio_e w_live_prio;
    logic [31:0] w_live_target;
    logic [31:0] w_next_pc;

    pc_next_sel #(
        .EXC_VECTOR    (EXC_VECTOR)
    ) u_pc_next_sel (
        .pc_q          (pc_q),
`ifdef PC_SEQ_EXC_EN
        .exc           (exc),
`endif
        .jr            (jr),
        .jr_target     (jr_target),
        .jump          (jump),
        .jump_target   (jump_target),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .pend_prio     (pend_prio_q),
        .pend_target   (pend_target_q),
        .live_prio     (w_live_prio),
        .live_target   (w_live_target),
        .next_pc       (w_next_pc)
    );

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= BOOT;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Next state and outputs. pc_en reacts to imem_ack/stall in the same
    // cycle so an accepted fetch advances the PC with no added latency.
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        pc_en       = 1'b0;
        imem_req    = 1'b0;
        fetch_valid = 1'b0;
        pc_d        = w_next_pc;

        case (state_q)
            BOOT: begin
                pc_en   = 1'b1;
                pc_d    = RESET_VECTOR;
                state_d = WAIT_ACK;
            end
            WAIT_ACK: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    fetch_valid = 1'b1;
                    if (stall) begin
                        state_d = HOLD;
                    end else begin
                        pc_en = 1'b1;
                    end
                end
            end
            HOLD: begin
                if (!stall) begin
                    pc_en   = 1'b1;
                    state_d = WAIT_ACK;
                end
            end
            default: begin
                state_d = BOOT;
            end
        endcase

        // Reset is asynchronous on the outputs too: the BOOT decode above
        // would otherwise assert pc_en while rst_n is still low.
        if (!rst_n) begin
            pc_en       = 1'b0;
            imem_req    = 1'b0;
            fetch_valid = 1'b0;
            pc_d        = RESET_VECTOR;
        end
    end

    // ------------------------------------------------------------------
    // Pending redirect slot. Any PC update (including the BOOT load)
    // consumes it; otherwise only a strictly higher live request replaces
    // the held one.
    // ------------------------------------------------------------------
    always_comb begin
        pend_prio_d   = pend_prio_q;
        pend_target_d = pend_target_q;
        if (pc_en) begin
            pend_prio_d   = RD_NONE;
            pend_target_d = '0;
        end else if (w_live_prio > pend_prio_q) begin
            pend_prio_d   = w_live_prio;
            pend_target_d = w_live_target;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_prio_q   <= RD_NONE;
            pend_target_q <= '0;
        end else begin
            pend_prio_q   <= pend_prio_d;
            pend_target_q <= pend_target_d;
        end
    end

endmodule : pc_sequencer
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pc_sequencer
//  Description : Directed self-checking bench for pc_sequencer. A small
//                program-counter register in the bench closes the loop
//                (pc_en/pc_d -> pc_q); scenarios may override pc_q.
//                Inputs change on the falling edge, outputs are sampled
//                1 time unit later.
//  Config      : PC_SEQ_EXC_EN - also connects and exercises exc.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] pc_q;
    logic [31:0] pc_d;
    logic        pc_en;
    logic        imem_req;
    logic        imem_ack;
    logic        fetch_valid;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        jump;
    logic [31:0] jump_target;
    logic        jr;
    logic [31:0] jr_target;
`ifdef PC_SEQ_EXC_EN
    logic        exc;
`endif

    logic [31:0] pc_reg;
    logic        ovr_en;
    logic [31:0] ovr_pc;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // External program counter register.
    always @(posedge clk) begin
        if (pc_en) pc_reg <= pc_d;
    end
    assign pc_q = ovr_en ? ovr_pc : pc_reg;

    pc_sequencer dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .pc_q          (pc_q),
        .pc_d          (pc_d),
        .pc_en         (pc_en),
        .imem_req      (imem_req),
        .imem_ack      (imem_ack),
        .fetch_valid   (fetch_valid),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .jump          (jump),
        .jump_target   (jump_target),
        .jr            (jr),
        .jr_target     (jr_target)
`ifdef PC_SEQ_EXC_EN
        ,
        .exc           (exc)
`endif
    );

    task automatic clear_inputs();
        imem_ack      = 1'b0;
        stall         = 1'b0;
        branch_taken  = 1'b0;
        branch_target = '0;
        jump          = 1'b0;
        jump_target   = '0;
        jr            = 1'b0;
        jr_target     = '0;
`ifdef PC_SEQ_EXC_EN
        exc           = 1'b0;
`endif
    endtask

    task automatic test_reset();
        rst_n  = 1'b0;
        ovr_en = 1'b0;
        ovr_pc = '0;
        clear_inputs();
        repeat (2) @(negedge clk);
        #1;
        checks++; if (pc_en !== 1'b0)       begin failures++; $display("FAIL rst_pc_en got=%b exp=0", pc_en); end
        checks++; if (imem_req !== 1'b0)    begin failures++; $display("FAIL rst_imem_req got=%b exp=0", imem_req); end
        checks++; if (fetch_valid !== 1'b0) begin failures++; $display("FAIL rst_fetch_valid got=%b exp=0", fetch_valid); end
        checks++; if (pc_d !== 32'h0)       begin failures++; $display("FAIL rst_pc_d got=%h exp=%h", pc_d, 32'h0); end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++; if (pc_en !== 1'b1)    begin failures++; $display("FAIL boot_pc_en got=%b exp=1", pc_en); end
        checks++; if (pc_d !== 32'h0)    begin failures++; $display("FAIL boot_pc_d got=%h exp=%h", pc_d, 32'h0); end
        checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL boot_imem_req got=%b exp=0", imem_req); end
    endtask

    task automatic test_sequential();
        logic [31:0] exp_pc;
        for (int i = 1; i <= 3; i++) begin
            exp_pc = 32'(i * 4);
            @(negedge clk);
            imem_ack = 1'b1;
            #1;
            checks++; if (pc_d !== exp_pc)      begin failures++; $display("FAIL seq_pc_d[%0d] got=%h exp=%h", i, pc_d, exp_pc); end
            checks++; if (pc_en !== 1'b1)       begin failures++; $display("FAIL seq_pc_en[%0d] got=%b exp=1", i, pc_en); end
            checks++; if (fetch_valid !== 1'b1) begin failures++; $display("FAIL seq_fetch_valid[%0d] got=%b exp=1", i, fetch_valid); end
        end
        @(negedge clk);
        imem_ack = 1'b0;
        #1;
        checks++; if (pc_en !== 1'b0)    begin failures++; $display("FAIL wait_pc_en got=%b exp=0", pc_en); end
        checks++; if (imem_req !== 1'b1) begin failures++; $display("FAIL wait_imem_req got=%b exp=1", imem_req); end
    endtask

    task automatic test_priority();
        @(negedge clk);
        ovr_en = 1'b1; ovr_pc = 32'h0000_0010;
        imem_ack = 1'b1;
        jump = 1'b1; jump_target = 32'h0000_0103;
        branch_taken = 1'b1; branch_target = 32'h0000_0040;
        #1;
        checks++; if (pc_d !== 32'h0000_0100) begin failures++; $display("FAIL prio_jump_over_branch got=%h exp=%h", pc_d, 32'h100); end
        checks++; if (pc_en !== 1'b1)         begin failures++; $display("FAIL prio_pc_en got=%b exp=1", pc_en); end
        @(negedge clk);
        jr = 1'b1; jr_target = 32'h0000_0301;
        #1;
        checks++; if (pc_d !== 32'h0000_0300) begin failures++; $display("FAIL prio_jr_over_jump got=%h exp=%h", pc_d, 32'h300); end
        @(negedge clk);
        jr = 1'b0; jump = 1'b0; branch_target = 32'h0000_0043;
        #1;
        checks++; if (pc_d !== 32'h0000_0040) begin failures++; $display("FAIL prio_branch_align got=%h exp=%h", pc_d, 32'h40); end
        @(negedge clk);
        clear_inputs();
        ovr_en = 1'b0;
    endtask

    task automatic test_pending();
        // pc_reg is 0x40 here; sequencer waits in WAIT_ACK.
        @(negedge clk);
        branch_taken = 1'b1; branch_target = 32'h0000_0080;
        #1;
        checks++; if (pc_en !== 1'b0)       begin failures++; $display("FAIL pend_no_update got=%b exp=0", pc_en); end
        checks++; if (fetch_valid !== 1'b0) begin failures++; $display("FAIL pend_fetch_valid got=%b exp=0", fetch_valid); end
        @(negedge clk);
        branch_taken = 1'b0; jr = 1'b1; jr_target = 32'h0000_0200;
        @(negedge clk);
        jr = 1'b0; branch_taken = 1'b1; branch_target = 32'h0000_0044;
        @(negedge clk);
        branch_taken = 1'b0; imem_ack = 1'b1;
        #1;
        checks++; if (pc_d !== 32'h0000_0200) begin failures++; $display("FAIL pend_jr_applied got=%h exp=%h", pc_d, 32'h200); end
        checks++; if (pc_en !== 1'b1)         begin failures++; $display("FAIL pend_pc_en got=%b exp=1", pc_en); end
        @(negedge clk);
        #1;
        checks++; if (pc_d !== 32'h0000_0204) begin failures++; $display("FAIL pend_cleared got=%h exp=%h", pc_d, 32'h204); end
        // Equal priority: live request wins over the pending one.
        @(negedge clk);
        imem_ack = 1'b0; jump = 1'b1; jump_target = 32'h0000_0500;
        @(negedge clk);
        imem_ack = 1'b1; jump_target = 32'h0000_0600;
        #1;
        checks++; if (pc_d !== 32'h0000_0600) begin failures++; $display("FAIL pend_tie_live got=%h exp=%h", pc_d, 32'h600); end
        @(negedge clk);
        jump = 1'b0;
        #1;
        checks++; if (pc_d !== 32'h0000_0604) begin failures++; $display("FAIL pend_tie_cleared got=%h exp=%h", pc_d, 32'h604); end
        // Pending higher than live wins.
        @(negedge clk);
        imem_ack = 1'b0; jr = 1'b1; jr_target = 32'h0000_0700;
        @(negedge clk);
        jr = 1'b0; imem_ack = 1'b1; branch_taken = 1'b1; branch_target = 32'h0000_0900;
        #1;
        checks++; if (pc_d !== 32'h0000_0700) begin failures++; $display("FAIL pend_over_live got=%h exp=%h", pc_d, 32'h700); end
        @(negedge clk);
        clear_inputs();
    endtask

    task automatic test_stall();
        int fv_cnt = 0;
        int en_cnt = 0;
        // pc_reg is 0x700 here.
        @(negedge clk);
        imem_ack = 1'b1; stall = 1'b1;
        #1;
        fv_cnt += int'(fetch_valid); en_cnt += int'(pc_en);
        checks++; if (fetch_valid !== 1'b1) begin failures++; $display("FAIL stall_fetch_valid got=%b exp=1", fetch_valid); end
        checks++; if (pc_en !== 1'b0)       begin failures++; $display("FAIL stall_ack_pc_en got=%b exp=0", pc_en); end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            imem_ack = 1'b0;
            #1;
            fv_cnt += int'(fetch_valid); en_cnt += int'(pc_en);
            checks++; if (pc_en !== 1'b0)    begin failures++; $display("FAIL hold_pc_en[%0d] got=%b exp=0", i, pc_en); end
            checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL hold_imem_req[%0d] got=%b exp=0", i, imem_req); end
        end
        @(negedge clk);
        stall = 1'b0;
        #1;
        fv_cnt += int'(fetch_valid); en_cnt += int'(pc_en);
        checks++; if (pc_en !== 1'b1)         begin failures++; $display("FAIL release_pc_en got=%b exp=1", pc_en); end
        checks++; if (pc_d !== 32'h0000_0704) begin failures++; $display("FAIL release_pc_d got=%h exp=%h", pc_d, 32'h704); end
        @(negedge clk);
        #1;
        fv_cnt += int'(fetch_valid); en_cnt += int'(pc_en);
        checks++; if (imem_req !== 1'b1) begin failures++; $display("FAIL after_hold_imem_req got=%b exp=1", imem_req); end
        checks++; if (fv_cnt !== 1)      begin failures++; $display("FAIL stall_fv_pulses got=%0d exp=1", fv_cnt); end
        checks++; if (en_cnt !== 1)      begin failures++; $display("FAIL stall_en_pulses got=%0d exp=1", en_cnt); end
    endtask

    task automatic test_wrap_exc();
        @(negedge clk);
        ovr_en = 1'b1; ovr_pc = 32'hFFFF_FFFC; imem_ack = 1'b1;
        #1;
        checks++; if (pc_d !== 32'h0000_0000) begin failures++; $display("FAIL wrap_pc_d got=%h exp=%h", pc_d, 32'h0); end
`ifdef PC_SEQ_EXC_EN
        @(negedge clk);
        exc = 1'b1; jr = 1'b1; jr_target = 32'h0000_0200;
        #1;
        checks++; if (pc_d !== 32'h8000_0180) begin failures++; $display("FAIL exc_over_jr got=%h exp=%h", pc_d, 32'h80000180); end
`endif
        @(negedge clk);
        clear_inputs();
        ovr_en = 1'b0;
    endtask

    task automatic test_reset_mid_hold();
        @(negedge clk);
        imem_ack = 1'b1; stall = 1'b1;
        @(negedge clk);
        // In HOLD: release stall (would update) and assert a late ack,
        // then drop reset mid-cycle.
        stall = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (pc_en !== 1'b0)       begin failures++; $display("FAIL midrst_pc_en got=%b exp=0", pc_en); end
        checks++; if (imem_req !== 1'b0)    begin failures++; $display("FAIL midrst_imem_req got=%b exp=0", imem_req); end
        checks++; if (fetch_valid !== 1'b0) begin failures++; $display("FAIL midrst_fetch_valid got=%b exp=0", fetch_valid); end
        checks++; if (pc_d !== 32'h0)       begin failures++; $display("FAIL midrst_pc_d got=%h exp=%h", pc_d, 32'h0); end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++; if (pc_en !== 1'b1)       begin failures++; $display("FAIL reboot_pc_en got=%b exp=1", pc_en); end
        checks++; if (pc_d !== 32'h0)       begin failures++; $display("FAIL reboot_pc_d got=%h exp=%h", pc_d, 32'h0); end
        checks++; if (fetch_valid !== 1'b0) begin failures++; $display("FAIL reboot_late_ack got=%b exp=0", fetch_valid); end
        @(negedge clk);
        #1;
        checks++; if (pc_d !== 32'h0000_0004) begin failures++; $display("FAIL reboot_first_fetch got=%h exp=%h", pc_d, 32'h4); end
        checks++; if (fetch_valid !== 1'b1)   begin failures++; $display("FAIL reboot_fetch_valid got=%b exp=1", fetch_valid); end
        @(negedge clk);
        clear_inputs();
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_priority();
        test_pending();
        test_stall();
        test_wrap_exc();
        test_reset_mid_hold();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

endmodule : tb_pc_sequencer
`default_nettype wire
